// File: rtl/sram_1rw_req_ctrl_if.sv
// Request/response/macro bundle for the 1RW SRAM request front end.
// slave = controller view, master = requester + macro side.
interface sram_1rw_req_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  resp_ready, sram_rdata,
        output req_ready, resp_valid, resp_rdata,
        output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        output resp_ready, sram_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
    );
endinterface

// File: rtl/sram_1rw_req_ctrl.sv
// Valid/ready front end for a 1RW sync-read SRAM macro. Requests drive the
// macro combinationally; read data is captured the cycle after the read
// fires into a small in-order response FIFO. Reads are credit-limited so the
// FIFO can always absorb every read already sent to the macro.
module sram_1rw_req_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 64,
    parameter int MASK_W     = 8,
    parameter int RESP_DEPTH = 3
) (
    input logic                 clock,
    input logic                 reset,
    sram_1rw_req_ctrl_if.slave  io_bus
);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int OCC_W = $clog2(RESP_DEPTH + 1);
    localparam logic [OCC_W:0]   LP_DEPTH = RESP_DEPTH[OCC_W:0];
    localparam logic [PTR_W-1:0] LP_LAST  = PTR_W'(RESP_DEPTH - 1);

    logic              r_rd_pend;
    logic [OCC_W-1:0]  r_occ;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_fifo [RESP_DEPTH];

    logic [OCC_W:0]    w_inflight;
    logic              w_ready;
    logic              w_fire;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_resp_valid;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == LP_LAST) ? '0 : p + 1'b1;
    endfunction

    // Reads already in the macro count against FIFO space; writes never do.
    // resp_ready is intentionally kept out of this path.
    assign w_inflight   = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_rd_pend};
    assign w_ready      = ~reset & (io_bus.req_write | (w_inflight < LP_DEPTH));
    assign w_fire       = io_bus.req_valid & w_ready;
    assign w_wr_fire    = w_fire & io_bus.req_write;
    assign w_rd_fire    = w_fire & ~io_bus.req_write;
    assign w_resp_valid = ~reset & (r_occ != '0);
    assign w_push       = ~reset & r_rd_pend;
    assign w_pop        = w_resp_valid & io_bus.resp_ready;

    assign io_bus.req_ready  = w_ready;
    assign io_bus.resp_valid = w_resp_valid;
    assign io_bus.resp_rdata = r_fifo[r_rd_ptr];

    // Macro sees the request in the same cycle; mask is zeroed unless writing.
    assign io_bus.sram_en    = w_fire;
    assign io_bus.sram_wmode = w_wr_fire;
    assign io_bus.sram_addr  = io_bus.req_addr;
    assign io_bus.sram_wdata = io_bus.req_wdata;
    assign io_bus.sram_wmask = w_wr_fire ? io_bus.req_wmask : '0;

    // Read-pending flag, FIFO pointers and occupancy; reset drops everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_occ     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_rd_pend <= w_rd_fire;
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Capture macro read data in the one cycle it is valid.
    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= io_bus.sram_rdata;
    end
endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Bench for sram_1rw_req_ctrl: behavioural 1RW macro, shadow memory for
// expected read data, and an in-order response scoreboard.
module tb_sram_1rw_req_ctrl;
    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 64;
    localparam int MASK_W     = 8;
    localparam int RESP_DEPTH = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_1rw_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    sram_1rw_req_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (bus)
    );

    // Behavioural macro: sync read, rdata held until the next read.
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] macro_q;
    assign bus.sram_rdata = macro_q;
    always @(posedge clock) begin
        if (bus.sram_en) begin
            if (bus.sram_wmode) begin
                for (int i = 0; i < MASK_W; i++)
                    if (bus.sram_wmask[i]) mem[bus.sram_addr][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
            end else begin
                macro_q <= mem[bus.sram_addr];
            end
        end
    end

    int n_tot = 0;
    int n_bad = 0;
    int n_resp = 0;
    logic [DATA_W-1:0] last_rd;
    logic [DATA_W-1:0] sh_mem [1 << ADDR_W];
    logic [DATA_W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor away from the active edge: what fires/pops at the next posedge.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_write) begin
                    for (int i = 0; i < MASK_W; i++)
                        if (bus.req_wmask[i]) sh_mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end else begin
                    exp_q.push_back(sh_mem[bus.req_addr]);
                end
            end
            if (bus.resp_valid && bus.resp_ready) begin
                n_resp++;
                last_rd <= bus.resp_rdata;
                if (exp_q.size() == 0) chk("resp_unexpected", 64'(bus.resp_rdata), 64'hx);
                else chk("resp_data", 64'(bus.resp_rdata), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
    endtask

    task automatic do_req(input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        int t;
        t = 0;
        drive(w, a, d, m);
        @(negedge clock);
        while (!bus.req_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!bus.req_ready) chk("req_timeout", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    function automatic logic [DATA_W-1:0] f_pat(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i);
    endfunction

    int acc;
    int a;
    int n0;
    int t;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wmask  = '0;
        bus.resp_ready = 1'b1;

        // Reset: a pending write must be blocked and macro controls idle.
        drive(1'b1, 9'h005, 64'h1, 8'hFF);
        tick();
        tick();
        @(negedge clock);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_sram_en", 64'(bus.sram_en), 64'd0);
        chk("rst_sram_wmode", 64'(bus.sram_wmode), 64'd0);
        chk("rst_sram_wmask", 64'(bus.sram_wmask), 64'd0);
        tick();
        reset = 1'b0;
        bus.req_valid = 1'b0;

        // Test 1: full write, read back, 2-cycle latency.
        drive(1'b1, 9'h005, 64'h1122334455667788, 8'hFF);
        @(negedge clock);
        chk("t1_wr_ready", 64'(bus.req_ready), 64'd1);
        chk("t1_wr_en", 64'(bus.sram_en), 64'd1);
        chk("t1_wr_wmode", 64'(bus.sram_wmode), 64'd1);
        chk("t1_wr_wmask", 64'(bus.sram_wmask), 64'hFF);
        chk("t1_wr_addr", 64'(bus.sram_addr), 64'h005);
        tick();
        drive(1'b0, 9'h005, 64'h0, 8'hFF);
        @(negedge clock);
        chk("t1_rd_en", 64'(bus.sram_en), 64'd1);
        chk("t1_rd_wmode", 64'(bus.sram_wmode), 64'd0);
        chk("t1_rd_wmask", 64'(bus.sram_wmask), 64'd0);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("t1_lat_n1", 64'(bus.resp_valid), 64'd0);
        tick();
        @(negedge clock);
        chk("t1_lat_n2", 64'(bus.resp_valid), 64'd1);
        chk("t1_data", 64'(bus.resp_rdata), 64'h1122334455667788);
        wait_drain("t1_drain");

        // Test 2: partial mask merges with the old word.
        do_req(1'b1, 9'h005, 64'hAAAAAAAABBBBBBBB, 8'h0F);
        do_req(1'b0, 9'h005, 64'h0, 8'h00);
        wait_drain("t2_drain");
        chk("t2_data", 64'(last_rd), 64'h11223344BBBBBBBB);

        // Test 3: credit limit with resp_ready low.
        for (int i = 0; i < 5; i++) do_req(1'b1, 9'(i), f_pat(i), 8'hFF);
        bus.resp_ready = 1'b0;
        acc = 0;
        a = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 9'(a), 64'h0, 8'h00);
            @(negedge clock);
            if (bus.req_ready) begin
                acc++;
                a++;
            end
            tick();
        end
        chk("t3_accepted", 64'(acc), 64'd3);
        @(negedge clock);
        chk("t3_ready_low", 64'(bus.req_ready), 64'd0);
        bus.resp_ready = 1'b1;
        t = 0;
        while (a < 5 && t < 50) begin
            drive(1'b0, 9'(a), 64'h0, 8'h00);
            @(negedge clock);
            if (bus.req_ready) a++;
            tick();
            t++;
        end
        bus.req_valid = 1'b0;
        chk("t3_all_sent", 64'(a), 64'd5);
        wait_drain("t3_drain");
        chk("t3_last", 64'(last_rd), f_pat(4));

        // Test 4: read then write same address back to back.
        do_req(1'b1, 9'h010, 64'h0123, 8'hFF);
        do_req(1'b0, 9'h010, 64'h0, 8'h00);
        do_req(1'b1, 9'h010, 64'hDEAD, 8'hFF);
        wait_drain("t4_drain_a");
        chk("t4_old", 64'(last_rd), 64'h0123);
        do_req(1'b0, 9'h010, 64'h0, 8'h00);
        wait_drain("t4_drain_b");
        chk("t4_new", 64'(last_rd), 64'hDEAD);

        // Test 5: streaming reads, one per cycle, ready never drops.
        n0 = n_resp;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 9'(c % 5), 64'h0, 8'h00);
            @(negedge clock);
            chk("t5_ready", 64'(bus.req_ready), 64'd1);
            if (c >= 2) chk("t5_resp_valid", 64'(bus.resp_valid), 64'd1);
            tick();
        end
        bus.req_valid = 1'b0;
        wait_drain("t5_drain");
        chk("t5_count", 64'(n_resp - n0), 64'd20);

        // Test 6: reset with one captured and one in-flight read.
        bus.resp_ready = 1'b0;
        do_req(1'b0, 9'h001, 64'h0, 8'h00);
        do_req(1'b0, 9'h002, 64'h0, 8'h00);
        n0 = n_resp;
        reset = 1'b1;
        drive(1'b0, 9'h003, 64'h0, 8'h00);
        @(negedge clock);
        chk("t6_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("t6_rst_sram_en", 64'(bus.sram_en), 64'd0);
        chk("t6_rst_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        reset = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clock);
        chk("t6_resume_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        wait_drain("t6_drain");
        chk("t6_resp_count", 64'(n_resp - n0), 64'd1);
        chk("t6_data", 64'(last_rd), f_pat(3));
        repeat (4) begin
            @(negedge clock);
            chk("t6_idle_valid", 64'(bus.resp_valid), 64'd0);
        end

        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
